bus_demux: RTL and testbench

BUS_DEMUX -- requirements
Module: bus_demux

---
 rtl/bus_demux_if.sv | 46 ++++
 rtl/bus_demux.sv | 107 ++++++++++
 tb/tb_bus_demux.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_demux_if.sv
// Bundle of the initiator port and both target ports of the 1-to-2 bus demux.
// slave is the demux's view; master is the environment (initiator plus targets).
interface bus_demux_if;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;

    logic        s0_valid;
    logic        s0_ready;
    logic        s0_we;
    logic [31:0] s0_addr;
    logic [31:0] s0_wdata;
    logic        s0_rvalid;
    logic [31:0] s0_rdata;

    logic        s1_valid;
    logic        s1_ready;
    logic        s1_we;
    logic [31:0] s1_addr;
    logic [31:0] s1_wdata;
    logic        s1_rvalid;
    logic [31:0] s1_rdata;

    modport slave (
        input  m_valid, m_we, m_addr, m_wdata,
        output m_ready, m_rvalid, m_rdata, m_err,
        output s0_valid, s0_we, s0_addr, s0_wdata,
        input  s0_ready, s0_rvalid, s0_rdata,
        output s1_valid, s1_we, s1_addr, s1_wdata,
        input  s1_ready, s1_rvalid, s1_rdata
    );

    modport master (
        output m_valid, m_we, m_addr, m_wdata,
        input  m_ready, m_rvalid, m_rdata, m_err,
        input  s0_valid, s0_we, s0_addr, s0_wdata,
        output s0_ready, s0_rvalid, s0_rdata,
        input  s1_valid, s1_we, s1_addr, s1_wdata,
        output s1_ready, s1_rvalid, s1_rdata
    );
endinterface

// File: rtl/bus_demux.sv
// Single-outstanding address demux: one initiator to two targets split at S1_BASE,
// with a per-transaction watchdog that completes with an error after TIMEOUT cycles.
module bus_demux #(
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    bus_demux_if.slave   bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        r_state;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_ready;
    logic          w_rv;
    logic [31:0]   w_rd;
    logic          w_to;

    always_comb begin
        w_ready = r_sel ? bus.s1_ready  : bus.s0_ready;
        w_rv    = r_sel ? bus.s1_rvalid : bus.s0_rvalid;
        w_rd    = r_sel ? bus.s1_rdata  : bus.s0_rdata;
        w_to    = (r_cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_sel    <= 1'b0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.m_valid) begin
                        r_we    <= bus.m_we;
                        r_addr  <= bus.m_addr;
                        r_wdata <= bus.m_wdata;
                        r_sel   <= (bus.m_addr >= S1_BASE);
                        r_cnt   <= '0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_to) begin
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= 32'hDEAD_BEEF;
                        r_state  <= IDLE;
                    end else if (w_ready) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A completion on the timeout edge still counts as success.
                    if (w_rv) begin
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b0;
                        r_rdata  <= r_we ? 32'h0 : w_rd;
                        r_state  <= IDLE;
                    end else if (w_to) begin
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= 32'hDEAD_BEEF;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.m_ready  = (r_state == IDLE);
    assign bus.m_rvalid = r_rvalid;
    assign bus.m_rdata  = r_rdata;
    assign bus.m_err    = r_err;

    // Target outputs are decoded from the latched request so the unselected side stays 0.
    assign bus.s0_valid = (r_state == ISSUE) && !r_sel;
    assign bus.s0_we    = r_we && !r_sel;
    assign bus.s0_addr  = r_sel ? 32'h0 : r_addr;
    assign bus.s0_wdata = r_sel ? 32'h0 : r_wdata;

    assign bus.s1_valid = (r_state == ISSUE) && r_sel;
    assign bus.s1_we    = r_we && r_sel;
    assign bus.s1_addr  = r_sel ? r_addr  : 32'h0;
    assign bus.s1_wdata = r_sel ? r_wdata : 32'h0;
endmodule

// File: tb/tb_bus_demux.sv
// Directed bench for bus_demux: stimulus pushes expected completions, a negedge
// monitor pops and compares them against m_rvalid pulses.
module tb_bus_demux;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   s1_seen = 1'b0;
    int   s0_hi = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;
    exp_t q[$];

    bus_demux_if bif();

    bus_demux #(.S1_BASE(32'h1000_0000), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (bif.s1_valid) s1_seen = 1'b1;
        if (bif.s0_valid) s0_hi++;
        if (bif.m_rvalid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid got rdata=%h err=%b at cycle %0d want no completion",
                         bif.m_rdata, bif.m_err, cyc);
            end else begin
                e = q.pop_front();
                if (bif.m_rdata !== e.d || bif.m_err !== e.e || cyc != e.c) begin
                    failures++;
                    $display("FAIL completion got rdata=%h err=%b cycle=%0d want rdata=%h err=%b cycle=%0d",
                             bif.m_rdata, bif.m_err, cyc, e.d, e.e, e.c);
                end
            end
        end
    end

    task automatic set_ready(input bit sel, input logic v);
        if (sel) bif.s1_ready = v; else bif.s0_ready = v;
    endtask

    task automatic set_rv(input bit sel, input logic v, input logic [31:0] d);
        if (sel) begin bif.s1_rvalid = v; bif.s1_rdata = d; end
        else     begin bif.s0_rvalid = v; bif.s0_rdata = d; end
    endtask

    // rv_dly < 0 means the target never completes (timeout path).
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit sel, input int rdy_dly, input int rv_dly,
                       input logic [31:0] rdata, input bit stray);
        exp_t e;
        int   acc;
        @(negedge clk);
        chk1("m_ready_idle", bif.m_ready, 1'b1);
        bif.m_valid = 1'b1; bif.m_we = we; bif.m_addr = addr; bif.m_wdata = wdata;
        @(posedge clk); #1;
        acc = cyc;
        bif.m_valid = 1'b0; bif.m_we = 1'b0; bif.m_addr = '0; bif.m_wdata = '0;
        if (rv_dly < 0) begin
            e.d = 32'hDEAD_BEEF; e.e = 1'b1; e.c = acc + TMO;
        end else begin
            e.d = we ? 32'h0 : rdata; e.e = 1'b0; e.c = acc + rdy_dly + rv_dly + 2;
        end
        q.push_back(e);
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            chk1("sel_valid",   sel ? bif.s1_valid : bif.s0_valid, 1'b1);
            chk1("other_valid", sel ? bif.s0_valid : bif.s1_valid, 1'b0);
            chk1("sel_we",      sel ? bif.s1_we    : bif.s0_we,    we);
            chk("sel_addr",     sel ? bif.s1_addr  : bif.s0_addr,  addr);
            chk("sel_wdata",    sel ? bif.s1_wdata : bif.s0_wdata, wdata);
            chk("other_addr",   sel ? bif.s0_addr  : bif.s1_addr,  32'h0);
            chk1("m_ready_busy", bif.m_ready, 1'b0);
            if (i == rdy_dly) set_ready(sel, 1'b1);
        end
        @(posedge clk); #1;
        set_ready(sel, 1'b0);
        @(negedge clk);
        chk1("valid_dropped", sel ? bif.s1_valid : bif.s0_valid, 1'b0);
        if (rv_dly < 0) begin
            repeat (TMO) @(negedge clk);
        end else begin
            for (int j = 0; j < rv_dly; j++) begin
                if (stray) begin bif.s1_rvalid = 1'b1; bif.s1_rdata = 32'hBAD0_0BAD; end
                @(negedge clk);
            end
            bif.s1_rvalid = 1'b0;
            set_rv(sel, 1'b1, rdata);
            @(posedge clk); #1;
            set_rv(sel, 1'b0, 32'h0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        exp_t e;
        bif.m_valid = 1'b0; bif.m_we = 1'b0; bif.m_addr = '0; bif.m_wdata = '0;
        bif.s0_ready = 1'b0; bif.s0_rvalid = 1'b0; bif.s0_rdata = '0;
        bif.s1_ready = 1'b0; bif.s1_rvalid = 1'b0; bif.s1_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_m_ready",  bif.m_ready,  1'b1);
        chk1("rst_m_rvalid", bif.m_rvalid, 1'b0);
        chk1("rst_m_err",    bif.m_err,    1'b0);
        chk("rst_m_rdata",   bif.m_rdata,  32'h0);
        chk1("rst_s0_valid", bif.s0_valid, 1'b0);
        chk1("rst_s1_valid", bif.s1_valid, 1'b0);
        chk("rst_s0_addr",   bif.s0_addr,  32'h0);
        chk("rst_s1_wdata",  bif.s1_wdata, 32'h0);
        rst = 1'b0;

        // Minimal-latency read to target 0
        s1_seen = 1'b0; s0_hi = 0;
        txn(1'b0, 32'h0000_0040, 32'h0, 1'b0, 0, 0, 32'h1234_5678, 1'b0);
        chk1("s1_never_valid", s1_seen, 1'b0);
        chk("s0_valid_cycles", 32'(s0_hi), 32'd1);

        // Write to target 1 with delayed ready; rdata must report 0
        txn(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 1'b1, 3, 1, 32'h5555_AAAA, 1'b0);
        chk("wr_rdata_hold", bif.m_rdata, 32'h0);

        // Address boundary
        txn(1'b0, 32'h0FFF_FFFC, 32'h0, 1'b0, 0, 0, 32'hAAAA_0001, 1'b0);
        txn(1'b0, 32'h1000_0000, 32'h0, 1'b1, 1, 0, 32'hBBBB_0002, 1'b0);
        txn(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 0, 2, 32'hBBBB_0003, 1'b0);

        // Timeout: target 0 accepts but never completes
        txn(1'b0, 32'h0000_0100, 32'h0, 1'b0, 0, -1, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("to_rdata_hold", bif.m_rdata, 32'hDEAD_BEEF);
        chk1("to_err_hold",  bif.m_err,   1'b1);

        // Stray target-1 completion while waiting on target 0
        txn(1'b0, 32'h0000_0200, 32'h0, 1'b0, 0, 3, 32'h0BAD_CAFE, 1'b1);
        chk1("err_cleared", bif.m_err, 1'b0);

        // Reset while in WAIT abandons the transaction
        @(negedge clk);
        bif.m_valid = 1'b1; bif.m_addr = 32'h0000_0300;
        @(posedge clk); #1;
        bif.m_valid = 1'b0; bif.m_addr = '0;
        @(negedge clk);
        bif.s0_ready = 1'b1;
        @(posedge clk); #1;
        bif.s0_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rstw_m_ready",  bif.m_ready,  1'b1);
        chk1("rstw_m_rvalid", bif.m_rvalid, 1'b0);
        chk("rstw_m_rdata",   bif.m_rdata,  32'h0);
        chk1("rstw_s0_valid", bif.s0_valid, 1'b0);
        bif.s0_rvalid = 1'b1; bif.s0_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bif.s0_rvalid = 1'b0;
        @(negedge clk);
        chk1("late_rvalid_ignored", bif.m_rvalid, 1'b0);
        chk1("late_m_ready",        bif.m_ready,  1'b1);

        // Back-to-back with m_valid held high
        @(negedge clk);
        bif.m_valid = 1'b1; bif.m_we = 1'b0; bif.m_addr = 32'h0000_0100;
        @(posedge clk); #1;
        acc1 = cyc;
        e.d = 32'h1111_2222; e.e = 1'b0; e.c = acc1 + 2;
        q.push_back(e);
        bif.m_addr = 32'h1000_0100;
        @(negedge clk);
        chk1("b2b_busy", bif.m_ready, 1'b0);
        bif.s0_ready = 1'b1;
        @(posedge clk); #1;
        bif.s0_ready = 1'b0; bif.s0_rvalid = 1'b1; bif.s0_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bif.s0_rvalid = 1'b0;
        @(negedge clk);
        chk1("b2b_rvalid", bif.m_rvalid, 1'b1);
        chk1("b2b_ready",  bif.m_ready,  1'b1);
        @(posedge clk); #1;
        acc2 = cyc;
        e.d = 32'h3333_4444; e.e = 1'b0; e.c = acc2 + 2;
        q.push_back(e);
        bif.m_valid = 1'b0; bif.m_addr = '0;
        @(negedge clk);
        chk1("b2b_s1_valid", bif.s1_valid, 1'b1);
        chk("b2b_s1_addr",   bif.s1_addr,  32'h1000_0100);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd3);
        bif.s1_ready = 1'b1;
        @(posedge clk); #1;
        bif.s1_ready = 1'b0; bif.s1_rvalid = 1'b1; bif.s1_rdata = 32'h3333_4444;
        @(posedge clk); #1;
        bif.s1_rvalid = 1'b0;
        repeat (3) @(negedge clk);

        chk("pending_completions", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
